// File: rtl/fb_arb_pkg.sv
// Shared types and constants for the frame-buffer port arbiter.
// Owner tags travel with each RAM access so the return data can be routed back.
package fb_arb_pkg;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_DISP = 2'd1,
      OWN_CPU  = 2'd2,
      OWN_ERR  = 2'd3
   } owner_e;

   localparam int FB_ADDR_W    = 32;
   localparam int FB_DATA_W    = 24;
   localparam int FB_ADDR_BASE = 24;
   localparam int FB_ADDR_LAST = 22525;

   localparam logic [23:0] WHITE     = 24'hFF_FF_FF;
   localparam logic [23:0] BLACK     = 24'h00_00_00;
   localparam logic [23:0] LIGHTBLUE = 24'hAD_D8_E6;

endpackage

// File: rtl/fb_port_arbiter_if.sv
// Bundle of scanout, CPU, stall-debug and RAM signals around the arbiter.
// The arbiter uses the slave view; the surrounding system uses the master view.
interface fb_port_arbiter_if
   import fb_arb_pkg::*;
#(
   parameter int ADDR_W  = FB_ADDR_W,
   parameter int DATA_W  = FB_DATA_W,
   parameter int STALL_W = 16
);
   logic              disp_req;
   logic [ADDR_W-1:0] disp_addr;
   logic [DATA_W-1:0] disp_data;
   logic              disp_valid;

   logic              cpu_req;
   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic              cpu_gnt;
   logic [DATA_W-1:0] cpu_rdata;
   logic              cpu_rvalid;
   logic              cpu_err;

   logic               stall_clr;
   logic [STALL_W-1:0] stall_cnt;

   logic [ADDR_W-1:0] mem_addr;
   logic              mem_we;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  disp_req, disp_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata,
             stall_clr, mem_rdata,
      output disp_data, disp_valid, cpu_gnt, cpu_rdata, cpu_rvalid, cpu_err,
             stall_cnt, mem_addr, mem_we, mem_wdata
   );

   modport master (
      output disp_req, disp_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata,
             stall_clr, mem_rdata,
      input  disp_data, disp_valid, cpu_gnt, cpu_rdata, cpu_rvalid, cpu_err,
             stall_cnt, mem_addr, mem_we, mem_wdata
   );
endinterface

// File: rtl/fb_tag_pipe.sv
// Delay line for access owner tags; depth matches issue register plus RAM latency.
// Reset flushes every stage so no stale completion is reported after reset.
module fb_tag_pipe
   import fb_arb_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic   clk_i,
   input  logic   rst_i,
   input  owner_e tag_i,
   output owner_e tag_o
);
   owner_e pipe_q [DEPTH];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < DEPTH; i++) pipe_q[i] <= OWN_NONE;
      end else begin
         pipe_q[0] <= tag_i;
         for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
      end
   end

   assign tag_o = pipe_q[DEPTH-1];
endmodule

// File: rtl/fb_port_arbiter.sv
// Single-port frame-buffer arbiter: scanout has strict priority, CPU fills idle slots.
// Out-of-range CPU accesses are completed with an error and never touch the RAM.
module fb_port_arbiter
   import fb_arb_pkg::*;
#(
   parameter int ADDR_W    = FB_ADDR_W,
   parameter int DATA_W    = FB_DATA_W,
   parameter int RD_LAT    = 1,
   parameter int ADDR_BASE = FB_ADDR_BASE,
   parameter int ADDR_LAST = FB_ADDR_LAST,
   parameter int STALL_W   = 16
) (
   input logic              VGA_CLK_IN,
   input logic              rst,
   fb_port_arbiter_if.slave bus
);
   localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(ADDR_BASE);
   localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(ADDR_LAST);

   owner_e owner_d;
   owner_e tag_ret;
   logic   cpu_gnt_c;
   logic   cpu_in_rng;

   logic [ADDR_W-1:0]  mem_addr_q;
   logic               mem_we_q;
   logic [DATA_W-1:0]  mem_wdata_q;
   logic [DATA_W-1:0]  disp_data_q;
   logic               disp_valid_q;
   logic [DATA_W-1:0]  cpu_rdata_q;
   logic               cpu_rvalid_q;
   logic               cpu_err_q;
   logic [STALL_W-1:0] stall_q;

   assign cpu_in_rng = (bus.cpu_addr >= BASE_A) && (bus.cpu_addr <= LAST_A);

   always_comb begin
      owner_d   = OWN_NONE;
      cpu_gnt_c = 1'b0;
      if (bus.disp_req) begin
         owner_d = OWN_DISP;
      end else if (bus.cpu_req) begin
         cpu_gnt_c = !rst;
         owner_d   = cpu_in_rng ? OWN_CPU : OWN_ERR;
      end
   end

   fb_tag_pipe #(.DEPTH(1 + RD_LAT)) u_tag_pipe (
      .clk_i (VGA_CLK_IN),
      .rst_i (rst),
      .tag_i (owner_d),
      .tag_o (tag_ret)
   );

   always_ff @(posedge VGA_CLK_IN) begin
      if (rst) begin
         mem_addr_q   <= '0;
         mem_we_q     <= 1'b0;
         mem_wdata_q  <= '0;
         disp_data_q  <= '0;
         disp_valid_q <= 1'b0;
         cpu_rdata_q  <= '0;
         cpu_rvalid_q <= 1'b0;
         cpu_err_q    <= 1'b0;
      end else begin
         mem_we_q <= 1'b0;
         case (owner_d)
            OWN_DISP: mem_addr_q <= bus.disp_addr;
            OWN_CPU: begin
               mem_addr_q  <= bus.cpu_addr;
               mem_we_q    <= bus.cpu_we;
               mem_wdata_q <= bus.cpu_wdata;
            end
            default: ;
         endcase

         // the tag leaving the pipe belongs to the RAM word on mem_rdata right now
         disp_valid_q <= 1'b0;
         cpu_rvalid_q <= 1'b0;
         cpu_err_q    <= 1'b0;
         case (tag_ret)
            OWN_DISP: begin
               disp_data_q  <= bus.mem_rdata;
               disp_valid_q <= 1'b1;
            end
            OWN_CPU: begin
               cpu_rdata_q  <= bus.mem_rdata;
               cpu_rvalid_q <= 1'b1;
            end
            OWN_ERR: begin
               cpu_rdata_q  <= '0;
               cpu_rvalid_q <= 1'b1;
               cpu_err_q    <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge VGA_CLK_IN) begin
      if (rst || bus.stall_clr) begin
         stall_q <= '0;
      end else if (bus.cpu_req && !cpu_gnt_c && (stall_q != '1)) begin
         stall_q <= stall_q + STALL_W'(1);
      end
   end

   assign bus.cpu_gnt    = cpu_gnt_c;
   assign bus.mem_addr   = mem_addr_q;
   assign bus.mem_we     = mem_we_q;
   assign bus.mem_wdata  = mem_wdata_q;
   assign bus.disp_data  = disp_data_q;
   assign bus.disp_valid = disp_valid_q;
   assign bus.cpu_rdata  = cpu_rdata_q;
   assign bus.cpu_rvalid = cpu_rvalid_q;
   assign bus.cpu_err    = cpu_err_q;
   assign bus.stall_cnt  = stall_q;
endmodule

// File: tb/tb_fb_port_arbiter.sv
// Directed bench for fb_port_arbiter: default instance plus an RD_LAT=3 / STALL_W=4 instance,
// each with its own write-first RAM model preloaded with a known pixel pattern.
module tb_fb_port_arbiter;
   import fb_arb_pkg::*;

   logic clk = 1'b0;
   logic rst;
   logic ram_load;
   int   n_vec  = 0;
   int   n_miss = 0;

   always #5 clk = ~clk;

   fb_port_arbiter_if #(.ADDR_W(32), .DATA_W(24), .STALL_W(16)) b0 ();
   fb_port_arbiter_if #(.ADDR_W(32), .DATA_W(24), .STALL_W(4))  b1 ();

   fb_port_arbiter #(.RD_LAT(1), .STALL_W(16)) dut0 (.VGA_CLK_IN(clk), .rst(rst), .bus(b0));
   fb_port_arbiter #(.RD_LAT(3), .STALL_W(4))  dut1 (.VGA_CLK_IN(clk), .rst(rst), .bus(b1));

   function automatic logic [23:0] pix(input int a);
      return {8'hC0 ^ a[7:0], a[15:0]};
   endfunction

   logic [23:0] ram0 [0:32767];
   logic [23:0] ram1 [0:32767];
   logic [23:0] rd0;
   logic [23:0] rd1a, rd1b, rd1c;
   int          we_cnt0 = 0;

   always @(posedge clk) begin
      if (ram_load) begin
         for (int i = 0; i < 32768; i++) ram0[i] <= pix(i);
      end else begin
         if (b0.mem_we) begin
            ram0[b0.mem_addr[14:0]] <= b0.mem_wdata;
            we_cnt0 <= we_cnt0 + 1;
         end
         rd0 <= b0.mem_we ? b0.mem_wdata : ram0[b0.mem_addr[14:0]];
      end
   end

   always @(posedge clk) begin
      if (ram_load) begin
         for (int i = 0; i < 32768; i++) ram1[i] <= pix(i);
      end else begin
         if (b1.mem_we) ram1[b1.mem_addr[14:0]] <= b1.mem_wdata;
         rd1a <= b1.mem_we ? b1.mem_wdata : ram1[b1.mem_addr[14:0]];
         rd1b <= rd1a;
         rd1c <= rd1b;
      end
   end

   assign b0.mem_rdata = rd0;
   assign b1.mem_rdata = rd1c;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cpu_op0(input logic we, input int addr, input logic [23:0] wd,
                          output logic gnt, output logic [23:0] rd, output logic err,
                          output int lat);
      b0.cpu_req   = 1'b1;
      b0.cpu_we    = we;
      b0.cpu_addr  = 32'(addr);
      b0.cpu_wdata = wd;
      #1 gnt = b0.cpu_gnt;
      tick();
      b0.cpu_req = 1'b0;
      b0.cpu_we  = 1'b0;
      lat = 1;
      while (!b0.cpu_rvalid && lat < 10) begin
         tick();
         lat++;
      end
      rd  = b0.cpu_rdata;
      err = b0.cpu_err;
   endtask

   logic        g, e;
   logic [23:0] rd;
   int          lat;
   int          we_before;
   int          nvalid;
   int          k;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      ram_load = 1'b1;
      b0.disp_req = 0; b0.disp_addr = 0; b0.cpu_req = 0; b0.cpu_we = 0;
      b0.cpu_addr = 0; b0.cpu_wdata = 0; b0.stall_clr = 0;
      b1.disp_req = 0; b1.disp_addr = 0; b1.cpu_req = 0; b1.cpu_we = 0;
      b1.cpu_addr = 0; b1.cpu_wdata = 0; b1.stall_clr = 0;

      tick();
      b0.cpu_req = 1'b1;
      b0.cpu_addr = 32'd100;
      #1 chk("gnt_in_rst", b0.cpu_gnt, 0);
      tick();
      tick();
      chk("rst_valid", b0.disp_valid, 0);
      chk("rst_rvalid", b0.cpu_rvalid, 0);
      chk("rst_stall", b0.stall_cnt, 0);
      chk("rst_mem_we", b0.mem_we, 0);
      b0.cpu_req = 1'b0;
      ram_load = 1'b0;
      rst = 1'b0;
      tick();

      // CPU write then read with idle display
      cpu_op0(1'b1, 100, 24'hABCDEF, g, rd, e, lat);
      chk("wr_gnt", g, 1);
      chk("wr_lat", lat, 3);
      chk("wr_err", e, 0);
      tick();
      chk("wr_pulse", b0.cpu_rvalid, 0);
      cpu_op0(1'b0, 100, 24'h0, g, rd, e, lat);
      chk("rd_gnt", g, 1);
      chk("rd_lat", lat, 3);
      chk("rd_data", rd, 24'hABCDEF);
      chk("rd_err", e, 0);
      tick();
      chk("rd_pulse", b0.cpu_rvalid, 0);

      // display burst blocks the CPU
      for (int i = 0; i < 12; i++) begin
         b0.disp_req  = (i < 10);
         b0.disp_addr = 32'(24 + i);
         b0.cpu_req   = (i <= 10);
         b0.cpu_we    = 1'b0;
         b0.cpu_addr  = 32'd200;
         #1;
         if (i <= 10) chk($sformatf("burst_gnt%0d", i), b0.cpu_gnt, (i == 10));
         if (i == 10) chk("burst_stall", b0.stall_cnt, 10);
         tick();
         if (i == 10) b0.cpu_req = 1'b0;
         chk($sformatf("burst_dv%0d", i), b0.disp_valid, (i >= 2));
         if (i >= 2) chk($sformatf("burst_dd%0d", i), b0.disp_data, pix(24 + i - 2));
      end
      tick();
      chk("burst_cpu_rv", b0.cpu_rvalid, 1);
      chk("burst_cpu_rd", b0.cpu_rdata, pix(200));
      chk("burst_dv_end", b0.disp_valid, 0);

      // out-of-range accesses
      we_before = we_cnt0;
      cpu_op0(1'b0, 23, 24'h0, g, rd, e, lat);
      chk("lo_gnt", g, 1);
      chk("lo_lat", lat, 3);
      chk("lo_err", e, 1);
      chk("lo_rdata", rd, 0);
      cpu_op0(1'b1, 22526, WHITE, g, rd, e, lat);
      chk("hi_gnt", g, 1);
      chk("hi_err", e, 1);
      chk("hi_rdata", rd, 0);
      tick();
      chk("oor_no_we", we_cnt0 - we_before, 0);
      chk("oor_ram", ram0[22526], pix(22526));

      // range edges
      cpu_op0(1'b1, 22525, LIGHTBLUE, g, rd, e, lat);
      chk("last_wr_err", e, 0);
      cpu_op0(1'b0, 22525, 24'h0, g, rd, e, lat);
      chk("last_rd", rd, LIGHTBLUE);
      chk("last_rd_err", e, 0);
      cpu_op0(1'b0, 24, 24'h0, g, rd, e, lat);
      chk("base_rd", rd, pix(24));
      chk("base_err", e, 0);

      // reset one cycle after a display read issues
      b0.disp_req = 1'b1;
      b0.disp_addr = 32'd30;
      tick();
      b0.disp_req = 1'b0;
      rst = 1'b1;
      b0.cpu_req = 1'b1;
      b0.cpu_addr = 32'd100;
      #1 chk("rst_gnt_forced", b0.cpu_gnt, 0);
      tick();
      rst = 1'b0;
      b0.cpu_req = 1'b0;
      chk("post_rst_dv", b0.disp_valid, 0);
      chk("post_rst_dd", b0.disp_data, 0);
      chk("post_rst_rv", b0.cpu_rvalid, 0);
      chk("post_rst_err", b0.cpu_err, 0);
      chk("post_rst_rd", b0.cpu_rdata, 0);
      chk("post_rst_stall", b0.stall_cnt, 0);
      chk("post_rst_maddr", b0.mem_addr, 0);
      chk("post_rst_mwd", b0.mem_wdata, 0);
      chk("post_rst_mwe", b0.mem_we, 0);
      nvalid = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (b0.disp_valid || b0.cpu_rvalid) nvalid++;
      end
      chk("post_rst_flush", nvalid, 0);

      // stall counter saturation on the narrow instance
      b1.disp_req = 1'b1;
      b1.disp_addr = 32'd60;
      b1.cpu_req = 1'b1;
      b1.cpu_addr = 32'd50;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (i == 14) chk("sat_14", b1.stall_cnt, 14);
         if (i == 15) chk("sat_15", b1.stall_cnt, 15);
         if (i == 20) chk("sat_20", b1.stall_cnt, 15);
      end
      b1.stall_clr = 1'b1;
      tick();
      chk("clr_wins", b1.stall_cnt, 0);
      b1.stall_clr = 1'b0;
      tick();
      chk("clr_recount", b1.stall_cnt, 1);
      b1.disp_req = 1'b0;
      #1 chk("sat_release_gnt", b1.cpu_gnt, 1);
      tick();
      b1.cpu_req = 1'b0;
      repeat (8) tick();

      // RD_LAT=3 alternating display / CPU reads
      for (int j = 0; j < 13; j++) begin
         if (j < 8) begin
            b1.disp_req  = (j % 2 == 0);
            b1.disp_addr = 32'(40 + j);
            b1.cpu_req   = (j % 2 == 1);
            b1.cpu_addr  = 32'(1000 + j);
         end else begin
            b1.disp_req = 1'b0;
            b1.cpu_req  = 1'b0;
         end
         tick();
         k = j - 4;
         chk($sformatf("alt_dv%0d", j), b1.disp_valid, (k >= 0 && k < 8 && k % 2 == 0));
         chk($sformatf("alt_rv%0d", j), b1.cpu_rvalid, (k >= 0 && k < 8 && k % 2 == 1));
         if (k >= 0 && k < 8 && k % 2 == 0)
            chk($sformatf("alt_dd%0d", j), b1.disp_data, pix(40 + k));
         if (k >= 0 && k < 8 && k % 2 == 1)
            chk($sformatf("alt_rd%0d", j), b1.cpu_rdata, pix(1000 + k));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule

// File: doc/fb_port_arbiter.md
Name: fb_port_arbiter

Overview:
- Shares the single-port frame-buffer RAM (24-bit RGB words) between two requesters.
  - The VGA scanout reader: pixel-address requests from the sync/timing block.
  - The CPU store/load port.
- Scanout has strict priority so the displayed pixel stream is never delayed. The CPU is served in idle slots through a req/gnt handshake.
- Sits between the VGA timing block, the CPU memory interface and the frame-buffer RAM. Also provides range checking and a CPU stall counter for debug.

Parameters:
- ADDR_W, 32, width of all address ports.
- DATA_W, 24, pixel word width ({R,G,B}).
- RD_LAT, 1, RAM read latency in cycles from the mem_addr edge to a valid mem_rdata (legal range 1..4).
- ADDR_BASE, 24, first legal frame-buffer address.
- ADDR_LAST, 22525, last legal frame-buffer address (inclusive).
- STALL_W, 16, width of the stall counter.

Ports:
- VGA_CLK_IN  in  1  single clock for the whole block.
- rst  in  1  synchronous, active-high reset.
- disp_req  in  1  scanout read request, one pixel per asserted cycle.
- disp_addr  in  ADDR_W  scanout pixel address.
- disp_data  out  DATA_W  returned pixel.
- disp_valid  out  1  disp_data valid pulse.
- cpu_req  in  1  CPU access request; held until granted.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_gnt  out  1  transfer accepted this cycle (combinational).
- cpu_rdata  out  DATA_W  CPU read data.
- cpu_rvalid  out  1  CPU completion pulse, issued for both reads and writes.
- cpu_err  out  1  completion was out of range; qualified by cpu_rvalid.
- stall_clr  in  1  clears stall_cnt.
- stall_cnt  out  STALL_W  cycles with cpu_req high and cpu_gnt low (saturating).
- mem_addr  out  ADDR_W  RAM address (registered).
- mem_we  out  1  RAM write enable (registered).
- mem_wdata  out  DATA_W  RAM write data (registered).
- mem_rdata  in  DATA_W  RAM read data.

Behaviour:
- Reset: all outputs 0; in-flight tags flushed, so no valid/rvalid pulse is emitted after the reset cycle for any request issued before or during it.
- Arbitration each cycle (combinational), with owner_e in {OWN_NONE, OWN_DISP, OWN_CPU, OWN_ERR}:
  - disp_req=1 → owner OWN_DISP; cpu_gnt=0.
  - else cpu_req=1 → cpu_gnt=1 (forced 0 while rst).
    - cpu_addr in [ADDR_BASE, ADDR_LAST] → OWN_CPU.
    - cpu_addr outside that range → OWN_ERR.
  - else → OWN_NONE.
- CPU handshake: transfer occurs on the edge where cpu_req && cpu_gnt. The CPU holds addr/we/wdata stable until then. There is no queueing; exactly one CPU op per grant.
- Issue (edge t):
  - OWN_DISP: mem_addr <= disp_addr, mem_we <= 0.
  - OWN_CPU: mem_addr <= cpu_addr, mem_we <= cpu_we, mem_wdata <= cpu_wdata.
  - OWN_NONE or OWN_ERR: mem_we <= 0, mem_addr holds.
  - An out-of-range CPU write never reaches the RAM.
- Return path: the owner tag travels a shift line of depth 1+RD_LAT. At edge t+1+RD_LAT, mem_rdata is registered into disp_data or cpu_rdata according to the tag.
  - OWN_DISP → disp_valid pulse.
  - OWN_CPU → cpu_rvalid pulse (cpu_rdata meaningful for reads only).
  - OWN_ERR → cpu_rvalid=1, cpu_err=1, cpu_rdata=0.
- Latency from request sample to valid is fixed at 2+RD_LAT cycles (3 with the default). Throughput is 1 op per cycle, back to back.
- The non-selected data output holds its last value; the valid pulses are 1 cycle wide.
- Read-after-write to the same address from the CPU: the write occurs at issue, so a following read returns the new data (the RAM must be write-first or have no same-cycle overlap).
- stall_cnt:
  - +1 per cycle with cpu_req && !cpu_gnt.
  - Saturates at all-ones.
  - stall_clr or rst forces 0; clear wins over a simultaneous increment.
- disp_addr is not range-checked; the scanout owner guarantees range.

Decomposition:
- Package fb_arb_pkg:
  - owner_e enum.
  - Default DATA_W / ADDR_W.
  - ADDR_BASE / ADDR_LAST frame constants.
  - Colour constants WHITE, BLACK, LIGHTBLUE.
- Sub-module fb_tag_pipe: a parameterised delay line for owner_e of depth 1+RD_LAT, with synchronous flush on rst.
- The arbiter top holds the grant logic, the issue registers, the return registers and the stall counter.

Test Plan:
- CPU write 0xABCDEF to addr 100 with idle display, then a read of 100 → cpu_gnt immediate; rvalid 3 cycles after each grant; read returns 0xABCDEF, cpu_err=0.
- disp_req held 10 cycles over addrs 24..33 with cpu_req high throughout → cpu_gnt=0 for all 10 cycles; 10 consecutive disp_valid pulses at 3-cycle latency with the RAM model data; stall_cnt=10; CPU granted in cycle 11.
- CPU read of addr 23, then a write to addr 22526 → both granted; each returns cpu_rvalid=1, cpu_err=1, cpu_rdata=0; RAM contents unchanged (mem_we never 1).
- Reset asserted one cycle after a display read is issued → no disp_valid follows; all outputs 0 the cycle after the reset edge.
- STALL_W=4, CPU blocked 20 cycles → stall_cnt saturates at 15; stall_clr on a blocked cycle → stall_cnt=0 next cycle.
- RD_LAT=3, alternating disp/CPU reads → each valid exactly 5 cycles after its request, routed to the correct requester, with no crossover.
